rtc_burst_ctrl: RTL and testbench



---
 rtl/rtc_burst_ctrl.sv | 159 +++++++++++++++
 tb/tb_rtc_burst_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_burst_ctrl.sv
// Burst sequencer for NREG consecutive RTC registers over a single-register I2C request interface.
// Adds per-transfer timeout, NACK retry, an atomic read shadow and an optional periodic auto-read.
module rtc_burst_ctrl #(
    parameter int         NREG        = 7,
    parameter logic [7:0] BASE_ADDR   = 8'h00,
    parameter int         RETRIES     = 2,
    parameter int         TIMEOUT_CYC = 200000,
    parameter int         POLL_CYC    = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_wr,
    input  logic              start_rd,
    input  logic              poll_en,
    input  logic [NREG*8-1:0] wr_vec,
    output logic [NREG*8-1:0] rd_vec,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        err_idx,
    output logic              wr_req,
    output logic              rd_req,
    output logic [7:0]        addr,
    output logic [7:0]        wr_data,
    input  logic [7:0]        rd_data,
    input  logic              rw_done,
    input  logic              nack
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_FIN  = 3'd3;
    localparam logic [2:0] S_FAIL = 3'd4;

    localparam int             TW        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int             PW        = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
    localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [PW-1:0]  POLL_LAST = PW'(POLL_CYC - 1);
    localparam logic [3:0]     IDX_LAST  = 4'(NREG - 1);
    localparam logic [2:0]     RETRY_MAX = 3'(RETRIES);

    logic [2:0]        state;
    logic              mode_rd;
    logic [3:0]        idx;
    logic [2:0]        retry_cnt;
    logic [TW-1:0]     to_cnt;
    logic [PW-1:0]     poll_cnt;
    logic              poll_pend;
    logic [NREG*8-1:0] snap;
    logic [NREG*8-1:0] shadow;
    logic [NREG*8-1:0] shadow_nxt;
    logic              go;
    logic              rd_go;

    function automatic logic [7:0] byte_at(input logic [NREG*8-1:0] v, input logic [3:0] n);
        return v[int'(n)*8 +: 8];
    endfunction

    // Start priority: write, then explicit read, then pending poll.
    assign go    = (state == S_IDLE) && (start_wr || start_rd || poll_pend);
    assign rd_go = (state == S_IDLE) && !start_wr && (start_rd || poll_pend);

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_FIN) || (state == S_FAIL);
    assign err    = (state == S_FAIL);
    assign wr_req = (state == S_REQ) && !mode_rd;
    assign rd_req = (state == S_REQ) && mode_rd;

    always_comb begin
        shadow_nxt = shadow;
        shadow_nxt[int'(idx)*8 +: 8] = rd_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mode_rd   <= 1'b0;
            idx       <= '0;
            retry_cnt <= '0;
            to_cnt    <= '0;
            snap      <= '0;
            shadow    <= '0;
            rd_vec    <= '0;
            err_idx   <= '0;
            addr      <= '0;
            wr_data   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        mode_rd   <= !start_wr;
                        snap      <= wr_vec;
                        idx       <= '0;
                        retry_cnt <= '0;
                        addr      <= BASE_ADDR;
                        wr_data   <= wr_vec[7:0];
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    to_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion in the same cycle as the timeout takes precedence.
                    if (rw_done && !nack) begin
                        if (mode_rd) shadow <= shadow_nxt;
                        retry_cnt <= '0;
                        if (idx == IDX_LAST) begin
                            // rd_vec only ever sees a complete, successful burst.
                            if (mode_rd) rd_vec <= shadow_nxt;
                            state <= S_FIN;
                        end else begin
                            idx     <= idx + 4'd1;
                            addr    <= BASE_ADDR + {4'd0, idx + 4'd1};
                            wr_data <= byte_at(snap, idx + 4'd1);
                            state   <= S_REQ;
                        end
                    end else if (rw_done || (to_cnt == TO_LAST)) begin
                        if (retry_cnt < RETRY_MAX) begin
                            retry_cnt <= retry_cnt + 3'd1;
                            state     <= S_REQ;
                        end else begin
                            err_idx <= idx;
                            state   <= S_FAIL;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_FIN, S_FAIL: state <= S_IDLE;
                default:       state <= S_IDLE;
            endcase
        end
    end

    // Poll timer; a tick landing on the same cycle as a read start stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_cnt  <= '0;
            poll_pend <= 1'b0;
        end else if (!poll_en) begin
            poll_cnt  <= '0;
            poll_pend <= 1'b0;
        end else begin
            if (rd_go) poll_pend <= 1'b0;
            if (POLL_CYC != 0) begin
                if (poll_cnt == POLL_LAST) begin
                    poll_cnt  <= '0;
                    poll_pend <= 1'b1;
                end else begin
                    poll_cnt <= poll_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rtc_burst_ctrl.sv
// Bench for rtc_burst_ctrl: a randomized I2C/RTC responder plus a burst-level reference model.
module tb_rtc_burst_ctrl;
    localparam int NREG    = 7;
    localparam int RETRIES = 2;
    localparam int TOC     = 100;
    localparam int POLLC   = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_wr, start_rd, poll_en;
    logic [NREG*8-1:0] wr_vec, rd_vec;
    logic              busy, done, err, wr_req, rd_req;
    logic [3:0]        err_idx;
    logic [7:0]        addr, wr_data, rd_data;
    logic              rw_done, nack;

    logic              start_rd2;
    logic [23:0]       rd_vec2;
    logic              busy2, done2, err2, wr_req2, rd_req2;
    logic [3:0]        err_idx2;
    logic [7:0]        addr2, wr_data2, rd_data2;
    logic              rw_done2;

    always #5 clk = ~clk;

    rtc_burst_ctrl #(.NREG(NREG), .BASE_ADDR(8'h00), .RETRIES(RETRIES),
                     .TIMEOUT_CYC(TOC), .POLL_CYC(POLLC)) dut (
        .clk(clk), .rst(rst), .start_wr(start_wr), .start_rd(start_rd), .poll_en(poll_en),
        .wr_vec(wr_vec), .rd_vec(rd_vec), .busy(busy), .done(done), .err(err), .err_idx(err_idx),
        .wr_req(wr_req), .rd_req(rd_req), .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .rw_done(rw_done), .nack(nack));

    // Three elements starting at FE to exercise the 8-bit address wrap.
    rtc_burst_ctrl #(.NREG(3), .BASE_ADDR(8'hFE), .RETRIES(0),
                     .TIMEOUT_CYC(50), .POLL_CYC(0)) dut2 (
        .clk(clk), .rst(rst), .start_wr(1'b0), .start_rd(start_rd2), .poll_en(1'b0),
        .wr_vec(24'h0), .rd_vec(rd_vec2), .busy(busy2), .done(done2), .err(err2), .err_idx(err_idx2),
        .wr_req(wr_req2), .rd_req(rd_req2), .addr(addr2), .wr_data(wr_data2), .rd_data(rd_data2),
        .rw_done(rw_done2), .nack(1'b0));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit is_wr; logic [7:0] a; logic [7:0] d; int c; } req_t;
    req_t       log_q[$];
    logic [7:0] log2_q[$];
    logic [7:0] mem [256];
    int         nack_left [256];
    int         silent;
    int         lat;
    logic [7:0] cur_a, cur_d;
    bit         cur_w;

    // RTC behind the I2C master: random latency, scripted NACKs, one optionally silent address.
    always begin
        @(negedge clk);
        rw_done = 1'b0;
        nack    = 1'b0;
        if (!rst && (wr_req || rd_req)) begin
            cur_w = wr_req; cur_a = addr; cur_d = wr_data;
            log_q.push_back('{cur_w, cur_a, cur_d, cyc});
            if (int'(cur_a) != silent) begin
                lat = $urandom_range(0, 3);
                repeat (lat + 1) @(negedge clk);
                rw_done = 1'b1;
                rd_data = mem[cur_a];
                if (nack_left[cur_a] > 0) begin
                    nack = 1'b1;
                    nack_left[cur_a]--;
                end else if (cur_w) begin
                    mem[cur_a] = cur_d;
                end
            end
        end
    end

    always begin
        @(negedge clk);
        rw_done2 = 1'b0;
        if (!rst && rd_req2) begin
            log2_q.push_back(addr2);
            @(negedge clk);
            rw_done2 = 1'b1;
            rd_data2 = addr2 ^ 8'h5A;
        end
    end

    int                tests = 0;
    int                fails = 0;
    logic [NREG*8-1:0] exp_rd;
    logic [3:0]        exp_eidx;
    int                last_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One burst: model expectations from the scripted faults, run it, compare everything.
    task automatic burst(input bit is_wr, input logic [NREG*8-1:0] wv, input string tag);
        req_t              exp_q[$];
        bit                ok = 1'b1;
        bit                seen = 1'b0;
        int                fidx = 0;
        int                f, n;
        logic [NREG*8-1:0] tmp;
        tmp = exp_rd;
        for (int i = 0; i < NREG; i++) begin
            f = (i == silent) ? 99 : nack_left[i];
            n = (f > RETRIES) ? RETRIES + 1 : f + 1;
            for (int k = 0; k < n; k++) exp_q.push_back('{is_wr, 8'(i), wv[i*8 +: 8], 0});
            if (f > RETRIES) begin ok = 1'b0; fidx = i; break; end
            tmp[i*8 +: 8] = mem[i];
        end
        if (ok && !is_wr) exp_rd = tmp;
        if (!ok) exp_eidx = 4'(fidx);

        log_q.delete();
        start_wr = is_wr; start_rd = !is_wr; wr_vec = wv;
        @(negedge clk);
        start_wr = 1'b0; start_rd = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        for (int c = 0; c < 20000 && !seen; c++) begin
            if (done) begin
                seen = 1'b1;
                last_done = cyc;
                check({tag, "_err"}, err, !ok);
            end else begin
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        @(negedge clk);
        check({tag, "_end"}, {busy, done, err}, 3'b000);
        check({tag, "_rd_vec"}, rd_vec, exp_rd);
        check({tag, "_err_idx"}, err_idx, exp_eidx);
        check({tag, "_nreq"}, log_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < log_q.size(); k++)
            check($sformatf("%s_req%0d", tag, k), {log_q[k].is_wr, log_q[k].a, log_q[k].d},
                  {exp_q[k].is_wr, exp_q[k].a, exp_q[k].d});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int                cs[$];
        int                dc[2];
        int                ndone;
        int                extra;
        bit                any_busy;
        bit                seen;
        logic [NREG*8-1:0] pw;
        rst = 1'b1; start_wr = 1'b0; start_rd = 1'b0; poll_en = 1'b0; wr_vec = '0;
        start_rd2 = 1'b0; rd_data = '0; rd_data2 = '0; silent = -1;
        exp_rd = '0; exp_eidx = '0; last_done = 0;
        for (int i = 0; i < 256; i++) begin mem[i] = 8'($urandom); nack_left[i] = 0; end
        repeat (3) @(negedge clk);
        check("reset_ctl", {busy, done, err, wr_req, rd_req, err_idx, addr, wr_data}, '0);
        check("reset_rd_vec", rd_vec, '0);
        rst = 1'b0;
        @(negedge clk);

        // Directed read with known RTC content.
        for (int i = 0; i < NREG; i++) mem[i] = 8'h10 + 8'(i);
        burst(1'b0, '0, "rd_basic");
        check("rd_basic_value", rd_vec, 56'h16151413121110);

        // Directed write, then read back what was written.
        burst(1'b1, 56'h24051906451230, "wr_basic");
        burst(1'b0, '0, "rd_back");
        check("rd_back_value", rd_vec, 56'h24051906451230);

        // Two NACKs on element 3 then success.
        nack_left[3] = 2;
        burst(1'b0, '0, "nack_retry");

        // Element 2 never answers: RETRIES+1 timeouts, each TOC+1 cycles apart.
        silent = 2;
        burst(1'b0, '0, "timeout");
        silent = -1;
        cs.delete();
        for (int k = 0; k < log_q.size(); k++) if (log_q[k].a == 8'd2) cs.push_back(log_q[k].c);
        check("timeout_nreq2", cs.size(), RETRIES + 1);
        if (cs.size() == RETRIES + 1) begin
            for (int k = 1; k < cs.size(); k++) check("timeout_gap", cs[k] - cs[k-1], TOC + 1);
            check("timeout_to_done", last_done - cs[RETRIES], TOC + 1);
        end

        // NACK exhaustion on element 5; err_idx must then hold across a good burst.
        nack_left[5] = RETRIES + 1;
        burst(1'b1, 56'hA1B2C3D4E5F607, "nack_fail");
        burst(1'b0, '0, "after_fail");

        for (int it = 0; it < 6; it++) begin
            bit                w;
            int                e;
            logic [NREG*8-1:0] v;
            w = 1'($urandom_range(0, 1));
            v = NREG*8'({$urandom(), $urandom()});
            e = $urandom_range(0, NREG - 1);
            nack_left[e] = $urandom_range(0, 3);
            burst(w, v, $sformatf("rnd%0d", it));
            nack_left[e] = 0;
        end

        // Poll tick coincident with start_wr: write first, then the polled read right after.
        pw = 56'h5566778899AABB;
        log_q.delete();
        poll_en = 1'b1;
        repeat (POLLC - 1) @(negedge clk);
        start_wr = 1'b1; wr_vec = pw;
        @(negedge clk);
        start_wr = 1'b0;
        ndone = 0; dc[0] = 0; dc[1] = 0;
        for (int c = 0; c < 3000 && ndone < 2; c++) begin
            start_rd = (c == 10);
            if (done) begin
                if (err) check("poll_err", err, 0);
                dc[ndone] = cyc;
                ndone++;
            end
            @(negedge clk);
        end
        start_rd = 1'b0;
        extra = 0;
        repeat (100) begin
            if (done) extra++;
            @(negedge clk);
        end
        poll_en = 1'b0;
        check("poll_bursts", ndone, 2);
        check("poll_no_queue", extra, 0);
        check("poll_nreq", log_q.size(), 2 * NREG);
        if (log_q.size() == 2 * NREG) begin
            for (int k = 0; k < 2 * NREG; k++)
                check($sformatf("poll_req%0d", k), {log_q[k].is_wr, log_q[k].a},
                      {k < NREG, 8'(k % NREG)});
            check("poll_back_to_back", log_q[NREG].c - dc[0], 2);
        end
        exp_rd = pw;
        check("poll_rd_vec", rd_vec, pw);

        // Dropping poll_en clears the poll counter, so two partial periods never tick.
        log_q.delete();
        any_busy = 1'b0;
        poll_en = 1'b1;
        repeat (600) begin @(negedge clk); any_busy |= busy; end
        poll_en = 1'b0;
        @(negedge clk);
        poll_en = 1'b1;
        repeat (600) begin @(negedge clk); any_busy |= busy; end
        poll_en = 1'b0;
        @(negedge clk);
        check("poll_clear_busy", any_busy, 0);
        check("poll_clear_nreq", log_q.size(), 0);

        // Asynchronous reset while waiting on element 4.
        silent = 4;
        log_q.delete();
        start_rd = 1'b1;
        @(negedge clk);
        start_rd = 1'b0;
        for (int c = 0; c < 2000 && log_q.size() < 5; c++) @(negedge clk);
        check("rst_reach_e4", log_q.size(), 5);
        repeat (10) @(negedge clk);
        check("rst_busy_before", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_ctl", {busy, done, err, wr_req, rd_req, err_idx, addr, wr_data}, '0);
        check("rst_async_rd_vec", rd_vec, '0);
        @(negedge clk);
        check("rst_no_done", {done, err}, 2'b00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        silent = -1;
        exp_rd = '0;
        exp_eidx = '0;
        @(negedge clk);
        burst(1'b0, '0, "post_rst");

        // Address wrap FE, FF, 00 on the second instance.
        log2_q.delete();
        start_rd2 = 1'b1;
        @(negedge clk);
        start_rd2 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 500 && !seen; c++) begin
            if (done2) begin seen = 1'b1; check("wrap_err", err2, 0); end
            else @(negedge clk);
        end
        check("wrap_done_seen", seen, 1);
        @(negedge clk);
        check("wrap_nreq", log2_q.size(), 3);
        if (log2_q.size() == 3) check("wrap_addrs", {log2_q[0], log2_q[1], log2_q[2]}, 24'hFEFF00);
        check("wrap_rd_vec", rd_vec2, 24'h5AA5A4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
